// File: rtl/prbs_lane_checker.sv
// prbs_lane_checker
// Parallel PRBS error checker with one self-seeding checker per lane, a lock
// state machine, and saturating error / word / loss-of-lock counters.
//
// Ports:
//   clk       word clock
//   rst       synchronous active-high reset
//   cke       word valid; low freezes all state, din ignored
//   chk_en    checker enable; low returns the FSM to IDLE
//   clr_cnt   synchronous clear of err_cnt, word_cnt, loss_cnt
//   eqn       tap mask shared by all lanes
//   din       received word, bit i belongs to lane i
//   locked    FSM is in LOCKED
//   state     IDLE=0, ACQ=1, SYNC=2, LOCKED=3
//   err_vec   per-lane mismatch of the last checked word
//   err_cnt   saturating lane-bit error count while LOCKED
//   word_cnt  saturating count of words checked while LOCKED
//   loss_cnt  saturating count of LOCKED->ACQ transitions
//
// Optional feature macro: PRBS_CHK_ERR_LOG_EN adds first_err_vec,
// first_err_word and first_err_vld, capturing the first errored LOCKED word.

module prbs_lane_checker #(
    parameter int unsigned N_LANES    = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ACQ_CYC    = 32,
    parameter int unsigned LOCK_CYC   = 64,
    parameter int unsigned WIN_CYC    = 256,
    parameter int unsigned UNLOCK_ERR = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cke,
    input  logic               chk_en,
    input  logic               clr_cnt,
    input  logic [31:0]        eqn,
    input  logic [N_LANES-1:0] din,
    output logic               locked,
    output logic [1:0]         state,
    output logic [N_LANES-1:0] err_vec,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   word_cnt,
    output logic [7:0]         loss_cnt
`ifdef PRBS_CHK_ERR_LOG_EN
    ,
    output logic [N_LANES-1:0] first_err_vec,
    output logic [CNT_W-1:0]   first_err_word,
    output logic               first_err_vld
`endif
);

    localparam int unsigned POP_W  = $clog2(N_LANES + 1);
    localparam int unsigned ACQ_W  = $clog2(ACQ_CYC + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_CYC + 1);
    localparam int unsigned WERR_W = $clog2(UNLOCK_ERR + N_LANES + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_SYNC   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t              state_q;
    logic [31:0]         lane_s [N_LANES];
    logic [ACQ_W-1:0]    acq_cnt;
    logic [LOCK_W-1:0]   clean_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [WERR_W-1:0]   win_err;
    logic                cnt_vld;

    logic [N_LANES-1:0]  err_c;
    logic [POP_W-1:0]    err_pop_c;
    logic [POP_W-1:0]    vec_pop_c;
    logic [WERR_W-1:0]   win_sum_c;
    logic [SUM_W-1:0]    err_sum_c;

    assign state = state_q;

    // Per-lane prediction from the lane's own received history, plus popcounts
    always_comb begin
        err_c     = '0;
        err_pop_c = '0;
        vec_pop_c = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            err_c[i]  = din[i] ^ (^(lane_s[i] & eqn));
            err_pop_c = err_pop_c + POP_W'(err_c[i]);
            vec_pop_c = vec_pop_c + POP_W'(err_vec[i]);
        end
        win_sum_c = win_err + WERR_W'(err_pop_c);
        err_sum_c = {1'b0, err_cnt} + SUM_W'(vec_pop_c);
    end

    // Lane state always seeds from received data, never from the prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_LANES); i++) lane_s[i] <= '0;
        end else if (cke) begin
            for (int i = 0; i < int'(N_LANES); i++) lane_s[i] <= {lane_s[i][30:0], din[i]};
        end
    end

    // Lock FSM, registered mismatch vector and the count stage one word behind
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            locked    <= 1'b0;
            acq_cnt   <= '0;
            clean_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            cnt_vld   <= 1'b0;
            err_vec   <= '0;
            err_cnt   <= '0;
            word_cnt  <= '0;
            loss_cnt  <= '0;
        end else if (cke) begin
            // Count stage: the word checked in LOCKED on the previous edge
            if (clr_cnt) begin
                err_cnt  <= '0;
                word_cnt <= '0;
                loss_cnt <= '0;
            end else if (cnt_vld) begin
                err_cnt <= err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
                if (!(&word_cnt)) word_cnt <= word_cnt + CNT_W'(1);
            end

            cnt_vld <= chk_en && (state_q == ST_LOCKED);
            err_vec <= (chk_en && (state_q == ST_SYNC || state_q == ST_LOCKED)) ? err_c : '0;

            if (!chk_en) begin
                state_q <= ST_IDLE;
                locked  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ACQ;
                        acq_cnt <= '0;
                    end
                    ST_ACQ: begin
                        if (acq_cnt == ACQ_W'(ACQ_CYC - 1)) begin
                            state_q   <= ST_SYNC;
                            clean_cnt <= '0;
                        end else begin
                            acq_cnt <= acq_cnt + ACQ_W'(1);
                        end
                    end
                    ST_SYNC: begin
                        if (|err_c) begin
                            clean_cnt <= '0;
                        end else if (clean_cnt == LOCK_W'(LOCK_CYC - 1)) begin
                            state_q <= ST_LOCKED;
                            locked  <= 1'b1;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            clean_cnt <= clean_cnt + LOCK_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (win_sum_c >= WERR_W'(UNLOCK_ERR)) begin
                            state_q <= ST_ACQ;
                            locked  <= 1'b0;
                            acq_cnt <= '0;
                            // clr_cnt in the same cycle already zeroed loss_cnt above
                            if (!clr_cnt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
                        end else if (win_cnt == WIN_W'(WIN_CYC - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_sum_c;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS_CHK_ERR_LOG_EN
    // Capture the first errored word seen by the count stage; word index is pre-increment
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_vec  <= '0;
            first_err_word <= '0;
            first_err_vld  <= 1'b0;
        end else if (cke) begin
            if (clr_cnt) begin
                first_err_vec  <= '0;
                first_err_word <= '0;
                first_err_vld  <= 1'b0;
            end else if (cnt_vld && (|err_vec) && !first_err_vld) begin
                first_err_vec  <= err_vec;
                first_err_word <= word_cnt;
                first_err_vld  <= 1'b1;
            end
        end
    end
`endif

endmodule
